keypad_scanner: RTL and testbench

Scans a 4x4 active-low matrix keypad and debounces the selected key. Each accepted press is emitted as a one-cycle `btn_valid` strobe with an ASCII `btn_char`. The block is the producer side of the calculator's key interface: its outputs drive the calculator FSM's `btn_valid`/`btn_char` inputs directly. Character set: `'0'`–`'9'`, `'+'`, `'-'`, `'*'`, `'='`, `'C'`, and 8'h08 (backspace).

---
 rtl/keypad_pkg.sv | 49 ++++
 rtl/keypad_scanner_input_sync.sv | 23 ++
 rtl/keypad_scanner.sv | 181 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and key map for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int unsigned KEY_ROWS = 4;
    localparam int unsigned KEY_COLS = 4;
    localparam logic [7:0]  KEY_BS   = 8'h08;

    typedef enum logic [1:0] {
        S_SCAN     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_HELD     = 2'd2
    } state_t;

    // ASCII code for the key at (row, col).
    function automatic logic [7:0] key_char(input logic [1:0] row, input logic [1:0] col);
        logic [7:0] ch;
        ch = 8'h00;
        case ({row, col})
            4'h0: ch = 8'h31;   // '1'
            4'h1: ch = 8'h32;   // '2'
            4'h2: ch = 8'h33;   // '3'
            4'h3: ch = 8'h2B;   // '+'
            4'h4: ch = 8'h34;   // '4'
            4'h5: ch = 8'h35;   // '5'
            4'h6: ch = 8'h36;   // '6'
            4'h7: ch = 8'h2D;   // '-'
            4'h8: ch = 8'h37;   // '7'
            4'h9: ch = 8'h38;   // '8'
            4'hA: ch = 8'h39;   // '9'
            4'hB: ch = 8'h2A;   // '*'
            4'hC: ch = 8'h43;   // 'C'
            4'hD: ch = 8'h30;   // '0'
            4'hE: ch = KEY_BS;
            4'hF: ch = 8'h3D;   // '='
        endcase
        return ch;
    endfunction

    // Index of the lowest-numbered active-low row.
    function automatic logic [1:0] lowest_low(input logic [3:0] rows_n);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows_n[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_input_sync.sv
// Parameterised-width two-flop synchronizer; both stages reset to 1 (idle pulled-up level).
module input_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with press/release debounce and one-cycle ASCII strobes.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned REPEAT_FIRST    = 25000000,
    parameter int unsigned REPEAT_NEXT     = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic       btn_valid,
    output logic [7:0] btn_char,
    output logic       key_held
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (SCAN_DIV < 4 || DEBOUNCE_CYCLES < 2 || REPEAT_FIRST < 1 || REPEAT_NEXT < 1) begin : g_param_check
        $error("keypad_scanner: parameter out of range");
    end

    state_t           state_q, state_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [1:0]       row_idx_q, row_idx_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       col_n_d;
    logic             btn_valid_d;
    logic [7:0]       btn_char_d;
    logic             key_held_d;
    logic [3:0]       row_s;
    logic             sel_row_s;

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_FIRST > REPEAT_NEXT) ? REPEAT_FIRST : REPEAT_NEXT;
    localparam int unsigned REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
    localparam logic [REP_W-1:0] REP_FIRST_LAST = REP_W'(REPEAT_FIRST - 1);
    localparam logic [REP_W-1:0] REP_NEXT_LAST  = REP_W'(REPEAT_NEXT - 1);

    logic [REP_W-1:0] rep_q, rep_d;
    logic             rep_started_q, rep_started_d;
`endif

    input_sync #(
        .WIDTH (4)
    ) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d   (row_n),
        .q   (row_s)
    );

    assign sel_row_s = row_s[row_idx_q];

    // Scan / debounce / hold sequencing and next-output computation.
    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        row_idx_d   = row_idx_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        btn_valid_d = 1'b0;
        btn_char_d  = btn_char;
`ifdef KEYPAD_REPEAT_EN
        rep_d         = rep_q;
        rep_started_d = rep_started_q;
`endif

        case (state_q)
            S_SCAN: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (row_s != 4'hF) begin
                        row_idx_d = lowest_low(row_s);
                        cnt_d     = '0;
                        state_d   = S_DEBOUNCE;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            S_DEBOUNCE: begin
                if (sel_row_s) begin
                    col_idx_d = col_idx_q + 2'd1;
                    div_d     = '0;
                    state_d   = S_SCAN;
                end else if (cnt_q == CNT_LAST) begin
                    btn_valid_d = 1'b1;
                    btn_char_d  = key_char(row_idx_q, col_idx_q);
                    cnt_d       = '0;
                    state_d     = S_HELD;
`ifdef KEYPAD_REPEAT_EN
                    rep_d         = '0;
                    rep_started_d = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_HELD: begin
                if (sel_row_s) begin
                    // Release must be stable; rep pauses rather than resets on a glitch.
                    if (cnt_q == CNT_LAST) begin
                        cnt_d     = '0;
                        col_idx_d = col_idx_q + 2'd1;
                        div_d     = '0;
                        state_d   = S_SCAN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
                    if (rep_q == (rep_started_q ? REP_NEXT_LAST : REP_FIRST_LAST)) begin
                        btn_valid_d   = 1'b1;
                        rep_d         = '0;
                        rep_started_d = 1'b1;
                    end else begin
                        rep_d = rep_q + REP_W'(1);
                    end
`endif
                end
            end

            default: begin
                state_d = S_SCAN;
            end
        endcase

        col_n_d    = ~(4'b0001 << col_idx_d);
        key_held_d = (state_d == S_HELD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_SCAN;
            col_idx_q <= 2'd0;
            row_idx_q <= 2'd0;
            div_q     <= '0;
            cnt_q     <= '0;
            col_n     <= 4'b1110;
            btn_valid <= 1'b0;
            btn_char  <= 8'h00;
            key_held  <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            row_idx_q <= row_idx_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            col_n     <= col_n_d;
            btn_valid <= btn_valid_d;
            btn_char  <= btn_char_d;
            key_held  <= key_held_d;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_q         <= '0;
            rep_started_q <= 1'b0;
        end else begin
            rep_q         <= rep_d;
            rep_started_q <= rep_started_d;
        end
    end
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: stimulus queues expected characters, a monitor checks strobes.
module tb_keypad_scanner;

    localparam int unsigned SCAN_DIV        = 4;
    localparam int unsigned DEBOUNCE_CYCLES = 8;
    localparam int unsigned REPEAT_FIRST    = 40;
    localparam int unsigned REPEAT_NEXT     = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic       btn_valid;
    logic [7:0] btn_char;
    logic       key_held;

    logic [3:0] press [4];
    logic [7:0] exp_q [$];
    logic       prev_valid = 1'b0;
    int         checks = 0;
    int         errors = 0;

    keypad_scanner #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_FIRST    (REPEAT_FIRST),
        .REPEAT_NEXT     (REPEAT_NEXT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_n     (row_n),
        .col_n     (col_n),
        .btn_valid (btn_valid),
        .btn_char  (btn_char),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_n[r] = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (press[r][c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    // Monitor: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (btn_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL strobe_unexpected: got char %02h, required no strobe", btn_char);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (btn_char !== e) begin
                        errors++;
                        $display("FAIL strobe_char: got %02h, required %02h", btn_char, e);
                    end
                end
                checks++;
                if (prev_valid) begin
                    errors++;
                    $display("FAIL strobe_back_to_back: got 2 consecutive cycles, required 1");
                end
            end
            prev_valid = btn_valid;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Release a key and wait (bounded) for key_held to drop, then let the bench settle.
    task automatic release_key(input int r, input int c, input string name);
        int n;
        press[r][c] = 1'b0;
        n = 0;
        while (key_held && n < 60) begin
            @(negedge clk);
            n++;
        end
        check({name, "_released"}, int'(key_held), 0);
        idle(20);
        check({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        int  n;
        logic exp_v;
        for (int r = 0; r < 4; r++) press[r] = 4'b0000;

        rst = 1'b1;
        idle(3);
        check("reset_col_n", int'(col_n), 32'hE);
        check("reset_btn_valid", int'(btn_valid), 0);
        check("reset_btn_char", int'(btn_char), 0);
        check("reset_key_held", int'(key_held), 0);
        rst = 1'b0;

        // 1: clean press r1/c2 -> '6'; key_held drops 8 cycles after synchronized release.
        exp_q.push_back(8'h36);
        press[1][2] = 1'b1;
        idle(40);
        check("t1_key_held", int'(key_held), 1);
        check("t1_btn_char", int'(btn_char), 32'h36);
        press[1][2] = 1'b0;
        n = 0;
        while (key_held && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("t1_release_cycles", n, 10);
        idle(20);
        check("t1_queue_empty", exp_q.size(), 0);

        // 2: bouncing r0/c0 then stable -> single '1'.
        exp_q.push_back(8'h31);
        for (int i = 0; i < 10; i++) begin
            press[0][0] = (i % 2 == 0);
            idle(3);
        end
        press[0][0] = 1'b1;
        idle(60);
        check("t2_key_held", int'(key_held), 1);
        release_key(0, 0, "t2");

        // 3: r0 and r2 low on column 0 -> lowest row wins, '1'.
        exp_q.push_back(8'h31);
        press[0][0] = 1'b1;
        press[2][0] = 1'b1;
        idle(60);
        check("t3_btn_char", int'(btn_char), 32'h31);
        press[2][0] = 1'b0;
        release_key(0, 0, "t3");

        // 4: backspace then '='.
        exp_q.push_back(8'h08);
        press[3][2] = 1'b1;
        idle(60);
        check("t4_bs_char", int'(btn_char), 32'h08);
        release_key(3, 2, "t4a");
        exp_q.push_back(8'h3D);
        press[3][3] = 1'b1;
        idle(60);
        check("t4_eq_char", int'(btn_char), 32'h3D);
        release_key(3, 3, "t4b");

        // 5: 5-cycle glitch on r2/c3 -> debounce abort, no strobe, next column is 0.
        n = 0;
        while (col_n !== 4'b0111 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("t5_col3_reached", int'(col_n), 32'h7);
        press[2][3] = 1'b1;
        n = 0;
        while (col_n === 4'b0111 && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 5) press[2][3] = 1'b0;
        end
        check("t5_col3_dwell", n, 8);
        check("t5_next_col", int'(col_n), 32'hE);
        check("t5_key_held", int'(key_held), 0);
        idle(20);
        check("t5_queue_empty", exp_q.size(), 0);

        // 6: hold r3/c1 for 100 cycles after first emit, then reset mid-hold.
        exp_q.push_back(8'h30);
`ifdef KEYPAD_REPEAT_EN
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h30);
`endif
        press[3][1] = 1'b1;
        n = 0;
        while (!btn_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("t6_first_strobe", int'(btn_valid), 1);
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
`ifdef KEYPAD_REPEAT_EN
            exp_v = (i == 40 || i == 56 || i == 72 || i == 88);
`else
            exp_v = 1'b0;
`endif
            if (btn_valid !== exp_v) begin
                checks++;
                errors++;
                $display("FAIL t6_repeat_at_%0d: got %0b, required %0b", i, btn_valid, exp_v);
            end else begin
                checks++;
            end
        end
        check("t6_key_held_before_rst", int'(key_held), 1);
        rst = 1'b1;
        press[3][1] = 1'b0;
        idle(2);
        check("t6_rst_col_n", int'(col_n), 32'hE);
        check("t6_rst_key_held", int'(key_held), 0);
        check("t6_rst_btn_valid", int'(btn_valid), 0);
        check("t6_rst_btn_char", int'(btn_char), 0);
        rst = 1'b0;
        @(negedge clk);
        check("t6_restart_col0", int'(col_n), 32'hE);
        idle(40);
        check("t6_queue_empty", exp_q.size(), 0);
        check("t6_key_held_after", int'(key_held), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
